uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive path of the SoC's memory-mapped UART. It deserialises 8N1 frames from `UART_RXD` and buffers the received bytes in a small FIFO. The bytes are handed to the CPU-side MMIO register block through a valid/ready handshake. The block sits between the board pin and the UART data/status registers polled by firmware, such as the serial console that echoes typed characters and parses commands.

## Interface
- `CLOCK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 1_000_000: line rate; 19_200 in FPGA builds.
- `FIFO_DEPTH`, default 8: receive buffer entries; must be a power of 2, ≥2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `serial_in`  in  1  raw RX pin; idles high; asynchronous to `clk`.
- `data_out`  out  8  byte at the FIFO head; 0 when empty.
- `data_out_valid`  out  1  FIFO non-empty.
- `data_out_ready`  in  1  consumer accepts the head byte this cycle.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `framing_err`  out  1  sticky; a stop bit was sampled low.
- `err_clr`  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- Input synchroniser: two flops, both reset to 1. All decoding uses the synchronised signal `rx_s`.
- Constants: N = CLOCK_FREQ/BAUD_RATE (integer division) and H = N/2.
- Receiver FSM states:
  - IDLE: on `rx_s`==0, clear the cycle counter and go to START.
  - START: at count H−1, sample `rx_s`. If 1, this is a false start: return to IDLE with no flag and no push. If 0, clear the counter and go to DATA.
  - DATA: sample `rx_s` at every count N−1 and shift it into bit[7] of the shift register, so the byte is assembled LSB first. After 8 samples, go to STOP.
  - STOP: at count N−1, sample `rx_s`.
    - If 1: push the shift register into the FIFO, then go to IDLE.
    - If 0: set `framing_err`, discard the byte, then go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. No new frame may start while the line is held low.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index.
  - Full when the indices are equal and the MSBs differ; empty when the pointers are equal.
- Push while full: the byte is dropped, `overrun` is set, and FIFO contents are unchanged. Exception: if a pop occurs in the same cycle, the push succeeds and `overrun` is not set.
- Pop when `data_out_valid && data_out_ready`. `data_out_ready` while empty has no effect.
- Push and pop in the same cycle when not full: both happen and `fifo_count` is unchanged.
- `err_clr` in the same cycle as a new error event: the set wins.
- Reset values:
  - FSM in IDLE, counter 0, shift register 0.
  - Pointers 0, `fifo_count`=0, `data_out_valid`=0, `data_out`=0.
  - `overrun`=0, `framing_err`=0.
- Reset asserted mid-frame aborts the frame immediately. A partial byte is never pushed.

## Timing
- Synchroniser latency: 2 cycles from the pin to `rx_s`.
- Counting from the cycle `rx_s` is first observed low (cycle 0):
  - start-bit sample at cycle H;
  - data bit k sample at H+(k+1)·N;
  - stop-bit sample and push at H+9N.
- `data_out_valid` rises the cycle after the push. For N=50 that is cycle 476, i.e. 478 cycles after the pin falls.
- `data_out` is registered and is valid in the same cycle as `data_out_valid`. After a pop, the next head byte (or 0) appears the following cycle.
- Sticky flags rise the cycle after the triggering sample and fall the cycle after `err_clr`.
- Back-to-back frames: a start edge is accepted on the first cycle after STOP returns to IDLE. This supports continuous 8N1 traffic with a stop bit of exactly N cycles.

## Structure
- Shared package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - `uart_cycles_per_bit(clock_freq, baud_rate)`;
  - the `UART_DATA_W`=8 constant, also used by the TX block.
- Sub-module `sync_fifo` (WIDTH, DEPTH) holds the storage, pointers, count and full/empty logic. It is reusable for the TX buffer.
- The top level contains the synchroniser, the receiver FSM, the sample counter and the sticky flags.

## Test plan
- Bench settings: CLOCK_FREQ=50e6, BAUD_RATE=1e6, `data_out_ready`=0 unless noted.
- Reset: `rst_n` low for 10 cycles → all outputs 0 and `data_out_valid`=0. Then drive frame 8'h78 → `data_out`=8'h78, `data_out_valid`=1 and `fifo_count`=1, exactly 478 cycles after the pin falls.
- Burst: send 8'h78, 8'h79, 8'h7a, 8'h0d back-to-back, then pulse `data_out_ready` for 4 single cycles → bytes popped in order, `fifo_count` goes 4→0, no flags set.
- Overrun: send 9 bytes (8'h30–8'h38) with no pops → `fifo_count`=8, `overrun`=1, head=8'h30, 8'h38 absent. Pulse `err_clr` → `overrun`=0.
- Framing / false start: send a frame with stop=0, holding the line low for 3 extra bit times → `framing_err`=1, no push, next frame 8'h31 received correctly. Then send a 10-cycle low glitch → no push, no flag.
- Simultaneous push/pop while full: fill the FIFO with 8 bytes, then hold `data_out_ready`=1 across the push cycle of a 9th byte 8'h3e → `overrun`=0, `fifo_count` returns to 8 at the push, 8'h3e is stored last.
- Reset mid-frame: assert `rst_n` low during data bit 4 of 8'h35 → FIFO empty, no flags. Frame 8'h20 sent after release → received as 8'h20.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and bit-timing helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int uart_cycles_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous circular FIFO with registered head output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     not_empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_next;
  logic [AW:0]      rd_next;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] head_d;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign not_empty = !empty;
  assign count     = wr_ptr - rd_ptr;

  // A pop frees the slot the incoming byte needs, so a full FIFO still accepts it.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_next = wr_ptr + (AW+1)'(push_ok);
  assign rd_next = rd_ptr + (AW+1)'(pop_ok);

  // Head is registered, so look ahead to what the head will be after this edge.
  always_comb begin
    head_d = '0;
    if (wr_next != rd_next) begin
      if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
        head_d = push_data;
      end else begin
        head_d = mem[rd_next[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      head   <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a byte FIFO with sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         serial_in,
  output logic [UART_DATA_W-1:0]       data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overrun,
  output logic                         framing_err,
  input  logic                         err_clr
);

  localparam int N     = uart_cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int H     = N / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);

  logic [1:0]             sync_q;
  logic                   rx_s;
  rx_state_t              state;
  rx_state_t              state_next;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   cnt_clr;
  logic                   shift_en;
  logic                   push;
  logic                   ferr_set;
  logic                   fifo_full;
  logic                   pop;
  logic                   ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_clr    = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (cnt == H_LAST) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == N_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == N_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[UART_DATA_W-1:1]};
      end
    end
  end

  assign pop     = data_out_valid && data_out_ready;
  assign ovr_set = push && fifo_full && !pop;

  // Set has priority over a simultaneous clear so no error event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (ferr_set) begin
        framing_err <= 1'b1;
      end else if (err_clr) begin
        framing_err <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .head      (data_out),
    .not_empty (data_out_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a byte-queue model.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int N      = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       framing_err;
  logic       err_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .overrun        (overrun),
    .framing_err    (framing_err),
    .err_clr        (err_clr)
  );

  always #10 clk = ~clk;

  // Called just after a rising edge; line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    serial_in = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (N) @(posedge clk);
      #1;
    end
    serial_in = stop;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic pop_one(output logic [7:0] b);
    b = data_out;
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    data_out_ready = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({data_out, data_out_valid, fifo_count, overrun, framing_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {data_out, data_out_valid, fifo_count, overrun, framing_err});
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fork
      send_frame(8'h78, 1'b1);
      begin
        repeat (477) @(posedge clk);
        #1;
        checks++;
        if (data_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: valid=%b expected 0 at cycle 477", data_out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({data_out_valid, data_out, fifo_count} !== {1'b1, 8'h78, 4'd1}) begin
          errors++;
          $display("FAIL latency_478: valid=%b data=%h count=%0d expected 1 78 1", data_out_valid, data_out, fifo_count);
        end
      end
    join
  endtask

  task automatic test_burst();
    logic [7:0] b;
    logic [7:0] bytes [4];
    bytes = '{8'h78, 8'h79, 8'h7a, 8'h0d};
    pop_one(b);
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fifo_count !== 4'(4 - i)) begin
        errors++;
        $display("FAIL burst_count: got %0d expected %0d", fifo_count, 4 - i);
      end
      pop_one(b);
      checks++;
      if (b !== bytes[i]) begin
        errors++;
        $display("FAIL burst_data: got %h expected %h", b, bytes[i]);
      end
    end
    checks++;
    if ({fifo_count, data_out_valid, overrun, framing_err} !== 7'd0) begin
      errors++;
      $display("FAIL burst_end: count=%0d valid=%b ovr=%b ferr=%b expected all 0", fifo_count, data_out_valid, overrun, framing_err);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h30 + 8'(i), 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'h30 + 8'(i));
    end
    checks++;
    if ({fifo_count, overrun, data_out} !== {4'd8, 1'b1, 8'h30}) begin
      errors++;
      $display("FAIL overrun_full: count=%0d ovr=%b head=%h expected 8 1 30", fifo_count, overrun, data_out);
    end
    pulse_err_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected 0", overrun);
    end
    while (exp_q.size() > 0) begin
      pop_one(b);
      checks++;
      if (b !== exp_q[0]) begin
        errors++;
        $display("FAIL overrun_drain: got %h expected %h", b, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_empty: valid=%b expected 0", data_out_valid);
    end
  endtask

  task automatic test_framing();
    logic [7:0] b;
    send_frame(8'($urandom), 1'b0);
    repeat (3 * N) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if ({framing_err, fifo_count} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL framing_set: ferr=%b count=%0d expected 1 0", framing_err, fifo_count);
    end
    send_frame(8'h31, 1'b1);
    checks++;
    if ({fifo_count, data_out} !== {4'd1, 8'h31}) begin
      errors++;
      $display("FAIL framing_next: count=%0d head=%h expected 1 31", fifo_count, data_out);
    end
    pop_one(b);
    pulse_err_clr();
    serial_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (2 * N) @(posedge clk);
    #1;
    checks++;
    if ({fifo_count, framing_err, overrun} !== 6'd0) begin
      errors++;
      $display("FAIL false_start: count=%0d ferr=%b ovr=%b expected 0 0 0", fifo_count, framing_err, overrun);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    fork
      send_frame(8'h3e, 1'b1);
      begin
        repeat (477) @(posedge clk);
        #1;
        checks++;
        if ({fifo_count, data_out} !== {4'd8, exp_q[0]}) begin
          errors++;
          $display("FAIL pushpop_before: count=%0d head=%h expected 8 %h", fifo_count, data_out, exp_q[0]);
        end
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h3e);
        checks++;
        if ({fifo_count, overrun} !== {4'd8, 1'b0}) begin
          errors++;
          $display("FAIL pushpop_after: count=%0d ovr=%b expected 8 0", fifo_count, overrun);
        end
      end
    join
    while (exp_q.size() > 0) begin
      pop_one(b);
      checks++;
      if (b !== exp_q[0]) begin
        errors++;
        $display("FAIL pushpop_drain: got %h expected %h", b, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'h35, 1'b1);
      begin
        repeat (5 * N + N / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
      end
    join
    checks++;
    if ({fifo_count, data_out_valid, overrun, framing_err} !== 7'd0) begin
      errors++;
      $display("FAIL midframe_reset: count=%0d valid=%b ovr=%b ferr=%b expected all 0", fifo_count, data_out_valid, overrun, framing_err);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h20, 1'b1);
    checks++;
    if ({fifo_count, data_out, framing_err} !== {4'd1, 8'h20, 1'b0}) begin
      errors++;
      $display("FAIL midframe_next: count=%0d head=%h ferr=%b expected 1 20 0", fifo_count, data_out, framing_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int n;
    pop_one(b);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
      end
      checks++;
      if (fifo_count !== 4'(n)) begin
        errors++;
        $display("FAIL random_count: got %0d expected %0d", fifo_count, n);
      end
      while (exp_q.size() > 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        pop_one(b);
        checks++;
        if (b !== exp_q[0]) begin
          errors++;
          $display("FAIL random_data: got %h expected %h", b, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      checks++;
      if ({data_out_valid, data_out, overrun, framing_err} !== 11'd0) begin
        errors++;
        $display("FAIL random_empty: valid=%b head=%h ovr=%b ferr=%b expected all 0", data_out_valid, data_out, overrun, framing_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overrun();
    test_framing();
    test_full_pushpop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
